// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: beat input, skewed lane output and product control for one array edge feeder.
interface systolic_skew_feeder_if #(
    parameter int N         = 4,
    parameter int DATA_BITS = 16,
    parameter int K_W       = 8
);
    logic                   start;
    logic [K_W-1:0]         k_len;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*DATA_BITS-1:0] in_data;
    logic [N*DATA_BITS-1:0] lane_out;
    logic                   acc_clr;
    logic                   busy;
    logic                   done;
    modport master (
        output start, k_len, in_valid, in_data,
        input  in_ready, lane_out, acc_clr, busy, done
    );
    modport slave (
        input  start, k_len, in_valid, in_data,
        output in_ready, lane_out, acc_clr, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews N-lane beats (lane i delayed i+1 cycles) into a systolic array edge,
// counts K beats, flushes zeros for 2N-1 cycles and pulses done once the array has drained.
module systolic_skew_feeder #(
    parameter int N         = 4,
    parameter int DATA_BITS = 16,
    parameter int K_W       = 8
) (
    input logic                  clk,
    input logic                  rst,
    systolic_skew_feeder_if.slave bus
);
    localparam int FW = $clog2(2 * N);
    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;
    state_t         state_q, state_d;
    logic [K_W-1:0] k_q, k_d, cnt_q, cnt_d;
    logic [FW-1:0]  flush_q, flush_d;
    logic           acc_clr_q, acc_clr_d;
    logic           accept;
    assign accept = bus.in_valid && state_q == FEED;
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        acc_clr_d = 1'b0;
        case (state_q)
            IDLE: if (bus.start && bus.k_len != '0) begin
                state_d   = FEED;
                k_d       = bus.k_len;
                cnt_d     = '0;
                acc_clr_d = 1'b1;
            end
            FEED: if (accept) begin
                cnt_d = cnt_q + K_W'(1);
                if (cnt_q + K_W'(1) == k_q) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end
            end
            FLUSH: begin
                flush_d = flush_q + FW'(1);
                state_d = flush_q == FW'(2 * N - 2) ? DONE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            flush_q   <= '0;
            acc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            acc_clr_q <= acc_clr_d;
        end
    end
    assign bus.in_ready = state_q == FEED;
    assign bus.busy     = state_q == FEED || state_q == FLUSH;
    assign bus.done     = state_q == DONE;
    assign bus.acc_clr  = acc_clr_q;
    // Non-accepted cycles inject zeros so bubbles and flush keep every lane aligned.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_BITS-1:0] sr_q [i+1];
        logic [DATA_BITS-1:0] sr_d [i+1];
        always_comb begin
            sr_d[0] = accept ? bus.in_data[i*DATA_BITS +: DATA_BITS] : '0;
            for (int j = 1; j <= i; j++) sr_d[j] = sr_q[j-1];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sr_q <= '{default: '0};
            else     sr_q <= sr_d;
        end
        assign bus.lane_out[i*DATA_BITS +: DATA_BITS] = sr_q[i];
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: two feeders (west/north) driving a behavioural 4x4 MAC array,
// checked cycle by cycle against a beat-timing scoreboard and a golden matmul.
module tb_systolic_skew_feeder;
    localparam int N = 4, DW = 16, K_W = 8, W = N * DW;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    systolic_skew_feeder_if #(.N(N), .DATA_BITS(DW), .K_W(K_W)) bus_w ();
    systolic_skew_feeder_if #(.N(N), .DATA_BITS(DW), .K_W(K_W)) bus_n ();
    assign bus_n.start    = bus_w.start;
    assign bus_n.k_len    = bus_w.k_len;
    assign bus_n.in_valid = bus_w.in_valid;
    systolic_skew_feeder #(.N(N), .DATA_BITS(DW), .K_W(K_W)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));
    systolic_skew_feeder #(.N(N), .DATA_BITS(DW), .K_W(K_W)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));
    int checks = 0, errors = 0, done_count = 0, done_t = -1;
    logic [DW-1:0] exp_w [16][N];
    logic [DW-1:0] exp_n [16][N];
    logic [W-1:0]  obs_w [64];
    logic [W-1:0]  beat_w [$];
    logic [W-1:0]  beat_n [$];
    bit            vpat [$];
    bit            rand_bub = 0, start_noise = 0;
    // Behavioural output-stationary array: a flows east, b flows south, one hop per cycle.
    logic signed [DW-1:0] a_q [N][N];
    logic signed [DW-1:0] b_q [N][N];
    longint               acc [N][N];
    function automatic logic signed [DW-1:0] a_in(input int r, input int c);
        return c == 0 ? $signed(bus_w.lane_out[r*DW +: DW]) : a_q[r][c-1];
    endfunction
    function automatic logic signed [DW-1:0] b_in(input int r, input int c);
        return r == 0 ? $signed(bus_n.lane_out[c*DW +: DW]) : b_q[r-1][c];
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
                a_q[r][c] <= '0;
                b_q[r][c] <= '0;
                acc[r][c] <= 0;
            end
        end else begin
            for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
                a_q[r][c] <= a_in(r, c);
                b_q[r][c] <= b_in(r, c);
                acc[r][c] <= bus_w.acc_clr ? 64'sd0 : acc[r][c] + longint'(a_in(r, c)) * longint'(b_in(r, c));
            end
        end
    end
    always @(posedge clk) if (!rst && bus_w.done) done_count <= done_count + 1;
    function automatic logic [W-1:0] mkbeat(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction
    // Runs one product from a start in an IDLE cycle (t=0); expectations come from beat timing:
    // accept at t -> lane i shows it at t+1+i, done at last accept + 2N, busy in between.
    task automatic run_product(input int k);
        int t = 0, pi = 0, bi = 0, got = 0, last = -1;
        bit feeding = 0, ended = 0, v, exp_busy, exp_done;
        logic [W-1:0] dw, dn;
        for (int s = 0; s < 16; s++) for (int i = 0; i < N; i++) begin
            exp_w[s][i] = '0;
            exp_n[s][i] = '0;
        end
        done_t = -1;
        while (!ended && t < 400) begin
            exp_busy = feeding || (last >= 0 && t <= last + 2 * N - 1);
            exp_done = last >= 0 && t == last + 2 * N;
            checks += 5;
            if (bus_w.in_ready !== feeding) begin errors++; $display("FAIL in_ready t=%0d got %b exp %b", t, bus_w.in_ready, feeding); end
            if (bus_w.busy !== exp_busy) begin errors++; $display("FAIL busy t=%0d got %b exp %b", t, bus_w.busy, exp_busy); end
            if (bus_w.done !== exp_done) begin errors++; $display("FAIL done t=%0d got %b exp %b", t, bus_w.done, exp_done); end
            if (bus_n.done !== exp_done) begin errors++; $display("FAIL done_n t=%0d got %b exp %b", t, bus_n.done, exp_done); end
            if (bus_w.acc_clr !== (t == 1)) begin errors++; $display("FAIL acc_clr t=%0d got %b exp %b", t, bus_w.acc_clr, t == 1); end
            for (int i = 0; i < N; i++) begin
                checks += 2;
                if (bus_w.lane_out[i*DW +: DW] !== exp_w[t%16][i]) begin
                    errors++; $display("FAIL lane_w%0d t=%0d got %h exp %h", i, t, bus_w.lane_out[i*DW +: DW], exp_w[t%16][i]);
                end
                if (bus_n.lane_out[i*DW +: DW] !== exp_n[t%16][i]) begin
                    errors++; $display("FAIL lane_n%0d t=%0d got %h exp %h", i, t, bus_n.lane_out[i*DW +: DW], exp_n[t%16][i]);
                end
                exp_w[t%16][i] = '0;
                exp_n[t%16][i] = '0;
            end
            if (t < 64) obs_w[t] = bus_w.lane_out;
            if (exp_done) begin
                done_t = t;
                ended  = 1;
            end else begin
                v  = feeding ? (pi < vpat.size() ? vpat[pi] : (rand_bub ? ($urandom_range(0, 2) != 0) : 1'b1))
                             : 1'($urandom_range(0, 1));
                dw = W'({$urandom, $urandom});
                dn = W'({$urandom, $urandom});
                bus_w.start = (t == 0) || (start_noise && exp_busy && $urandom_range(0, 1) == 1);
                bus_w.k_len = t == 0 ? K_W'(k) : K_W'($urandom);
                if (feeding) begin
                    pi++;
                    if (v) begin
                        dw = bi < beat_w.size() ? beat_w[bi] : dw;
                        dn = bi < beat_n.size() ? beat_n[bi] : dn;
                        for (int i = 0; i < N; i++) begin
                            exp_w[(t+1+i)%16][i] = dw[i*DW +: DW];
                            exp_n[(t+1+i)%16][i] = dn[i*DW +: DW];
                        end
                        bi++;
                        got++;
                        if (got == k) begin
                            feeding = 0;
                            last    = t;
                        end
                    end
                end
                if (t == 0) feeding = 1;
                bus_w.in_valid = v;
                bus_w.in_data  = dw;
                bus_n.in_data  = dn;
                @(negedge clk);
                t++;
            end
        end
        if (!ended) begin
            checks++; errors++;
            $display("FAIL product_timeout k=%0d got no done exp done within 400 cycles", k);
        end
        bus_w.start    = 0;
        bus_w.in_valid = 0;
        @(negedge clk);
    endtask
    task automatic test_reset();
        int d0;
        bus_w.start = 0; bus_w.k_len = '0; bus_w.in_valid = 0; bus_w.in_data = '0; bus_n.in_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr} !== 4'b0 || bus_w.lane_out !== '0) begin
            errors++; $display("FAIL reset_hold got %b/%h exp 0/0", {bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr}, bus_w.lane_out);
        end
        rst = 0;
        @(negedge clk);
        d0 = done_count;
        bus_w.start = 1; bus_w.k_len = 8'd10; bus_w.in_valid = 1;
        bus_w.in_data = W'({$urandom, $urandom}) | W'(1); bus_n.in_data = bus_w.in_data;
        @(negedge clk);
        bus_w.start = 0;
        repeat (3) begin
            bus_w.in_data = W'({$urandom, $urandom}) | W'(1); bus_n.in_data = bus_w.in_data;
            @(negedge clk);
        end
        checks++;
        if (bus_w.busy !== 1'b1 || bus_w.lane_out[0 +: DW] === '0) begin
            errors++; $display("FAIL reset_prefeed got busy=%b lane0=%h exp busy=1 lane0!=0", bus_w.busy, bus_w.lane_out[0 +: DW]);
        end
        #2 rst = 1;
        #1;
        checks += 2;
        if ({bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr} !== 4'b0) begin
            errors++; $display("FAIL reset_async_flags got %b exp 0000", {bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr});
        end
        if (bus_w.lane_out !== '0 || bus_n.lane_out !== '0) begin
            errors++; $display("FAIL reset_async_lanes got %h/%h exp 0", bus_w.lane_out, bus_n.lane_out);
        end
        @(negedge clk);
        rst = 0;
        repeat (2 * N + 2) begin
            @(negedge clk);
            checks++;
            if ({bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr} !== 4'b0 || bus_w.lane_out !== '0) begin
                errors++; $display("FAIL reset_after got %b/%h exp 0000/0", {bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr}, bus_w.lane_out);
            end
        end
        bus_w.in_valid = 0;
        checks++;
        if (done_count !== d0) begin errors++; $display("FAIL reset_no_done got %0d exp %0d", done_count - d0, 0); end
    endtask
    task automatic test_k_zero();
        bus_w.start = 1; bus_w.k_len = '0; bus_w.in_valid = 1;
        @(negedge clk);
        bus_w.start = 0;
        repeat (4) begin
            bus_w.in_data = W'({$urandom, $urandom}); bus_n.in_data = bus_w.in_data;
            checks++;
            if ({bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr} !== 4'b0 || bus_w.lane_out !== '0) begin
                errors++; $display("FAIL k_zero got %b/%h exp 0000/0", {bus_w.in_ready, bus_w.busy, bus_w.done, bus_w.acc_clr}, bus_w.lane_out);
            end
            @(negedge clk);
        end
        bus_w.in_valid = 0;
    endtask
    task automatic test_basic();
        beat_w = '{mkbeat(1, 2, 3, 4), mkbeat(5, 6, 7, 8), mkbeat(9, 10, 11, 12)};
        run_product(3);
        for (int b = 0; b < 3; b++) begin
            checks += 2;
            if (obs_w[2+b][0 +: DW] !== DW'(1 + 4 * b)) begin
                errors++; $display("FAIL basic_lane0 t=%0d got %0d exp %0d", 2 + b, obs_w[2+b][0 +: DW], 1 + 4 * b);
            end
            if (obs_w[5+b][3*DW +: DW] !== DW'(4 + 4 * b)) begin
                errors++; $display("FAIL basic_lane3 t=%0d got %0d exp %0d", 5 + b, obs_w[5+b][3*DW +: DW], 4 + 4 * b);
            end
        end
        checks++;
        if (done_t !== 3 + 8) begin errors++; $display("FAIL basic_done_t got %0d exp %0d", done_t, 11); end
        beat_w.delete();
    endtask
    task automatic test_bubbles();
        beat_w = '{mkbeat(10, 20, 30, 40), mkbeat(50, 60, 70, 80)};
        vpat   = '{1, 0, 1};
        run_product(2);
        for (int i = 0; i < N; i++) begin
            checks += 3;
            if (obs_w[2+i][i*DW +: DW] !== DW'(10 * (i + 1))) begin
                errors++; $display("FAIL bubble_first lane%0d got %0d exp %0d", i, obs_w[2+i][i*DW +: DW], 10 * (i + 1));
            end
            if (obs_w[3+i][i*DW +: DW] !== '0) begin
                errors++; $display("FAIL bubble_gap lane%0d got %0d exp 0", i, obs_w[3+i][i*DW +: DW]);
            end
            if (obs_w[4+i][i*DW +: DW] !== DW'(10 * (i + 5))) begin
                errors++; $display("FAIL bubble_second lane%0d got %0d exp %0d", i, obs_w[4+i][i*DW +: DW], 10 * (i + 5));
            end
        end
        checks++;
        if (done_t !== 3 + 2 * N) begin errors++; $display("FAIL bubble_done_t got %0d exp %0d", done_t, 3 + 2 * N); end
        beat_w.delete();
        vpat.delete();
    endtask
    task automatic test_back_to_back();
        int d0 = done_count;
        start_noise = 1;
        rand_bub    = 1;
        run_product(4);
        run_product(3);
        run_product(1);
        start_noise = 0;
        rand_bub    = 0;
        checks++;
        if (done_count - d0 !== 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", done_count - d0); end
    endtask
    task automatic test_signed();
        beat_w = '{mkbeat('h8000, 'h7FFF, 'h8000, 'h7FFF), mkbeat('h7FFF, 'h8000, 'h0001, 'hFFFF)};
        run_product(2);
        for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) begin
            checks++;
            if (obs_w[2+b+i][i*DW +: DW] !== beat_w[b][i*DW +: DW]) begin
                errors++; $display("FAIL signed b%0d lane%0d got %h exp %h", b, i, obs_w[2+b+i][i*DW +: DW], beat_w[b][i*DW +: DW]);
            end
        end
        beat_w.delete();
    endtask
    task automatic test_random();
        rand_bub = 1;
        for (int n = 0; n < 5; n++) run_product(int'($urandom_range(1, 9)));
        rand_bub = 0;
    endtask
    task automatic test_full_system();
        logic signed [DW-1:0] ma [N][5];
        logic signed [DW-1:0] mb [5][N];
        logic [W-1:0] bw, bn;
        longint g;
        for (int kk = 0; kk < 5; kk++) begin
            for (int i = 0; i < N; i++) begin
                ma[i][kk] = DW'($urandom);
                mb[kk][i] = DW'($urandom);
                bw[i*DW +: DW] = ma[i][kk];
                bn[i*DW +: DW] = mb[kk][i];
            end
            beat_w.push_back(bw);
            beat_n.push_back(bn);
        end
        rand_bub = 1;
        run_product(5);
        rand_bub = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) begin
            g = 0;
            for (int kk = 0; kk < 5; kk++) g += longint'(ma[r][kk]) * longint'(mb[kk][c]);
            checks++;
            if (acc[r][c] !== g) begin errors++; $display("FAIL matmul c[%0d][%0d] got %0d exp %0d", r, c, acc[r][c], g); end
        end
        beat_w.delete();
        beat_n.delete();
    endtask
    initial begin
        test_reset();
        test_k_zero();
        test_basic();
        test_bubbles();
        test_back_to_back();
        test_signed();
        test_random();
        test_full_system();
        test_full_system();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
